// File: rtl/song_ctrl_pkg.sv
// Shared definitions for the song playback controller: state encoding,
// ROM entry field helpers and the song-region base address.
package song_ctrl_pkg;

  localparam int ROM_ADDR_W = 8;
  localparam int SONG_SEL_W = 2;

  localparam logic [3:0] END_DUR = 4'h0;
  localparam logic [3:0] SILENCE = 4'h0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    PLAY   = 3'd3,
    PAUSED = 3'd4
  } state_t;

  // First ROM address of song s when the ROM is split into equal regions.
  function automatic logic [31:0] song_base(input int unsigned s,
                                            input int unsigned addr_w,
                                            input int unsigned song_w);
    return 32'(s) << (addr_w - song_w);
  endfunction

  // Duration field of a ROM entry; zero marks the end of a song.
  function automatic logic [3:0] rom_dur(input logic [7:0] entry);
    return entry[7:4];
  endfunction

  // Tone field of a ROM entry.
  function automatic logic [3:0] rom_tone(input logic [7:0] entry);
    return entry[3:0];
  endfunction

endpackage

// File: rtl/song_ctrl.sv
// Playback controller: walks one song region of the song ROM note by note,
// restarting the music timer per note and driving tone/duration outputs.
module song_ctrl
  import song_ctrl_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int SONG_W = SONG_SEL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop,
  input  logic [SONG_W-1:0] song_sel,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  input  logic              note_change,
  output logic              note_start,
  output logic              timer_en,
  output logic [3:0]        dur_out,
  output logic [3:0]        tone_out,
  output logic              busy,
  output logic              done
);

  localparam int OFF_W = ADDR_W - SONG_W;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [SONG_W-1:0]   song_q, song_d;
  logic                loop_q, loop_d;
  logic [3:0]          note_tone_q, note_tone_d;
  logic [3:0]          dur_q, dur_d;
  logic [3:0]          tone_out_q, tone_out_d;
  logic                note_start_q, note_start_d;
  logic                timer_en_q, timer_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Next-state logic and registered-output precomputation.
  always_comb begin
    state_d      = state_q;
    rom_addr_d   = rom_addr_q;
    song_d       = song_q;
    loop_d       = loop_q;
    note_tone_d  = note_tone_q;
    dur_d        = dur_q;
    note_start_d = 1'b0;
    done_d       = 1'b0;

    if (stop) begin
      // Abort wins over everything; in IDLE this also swallows a play.
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (play) begin
            song_d      = song_sel;
            loop_d      = loop;
            rom_addr_d  = ADDR_W'(song_base(int'(song_sel), ADDR_W, SONG_W));
            note_tone_d = SILENCE;
            state_d     = FETCH;
          end
        end
        FETCH: begin
          state_d = LOAD;
        end
        LOAD: begin
          if (rom_dur(rom_data) == END_DUR) begin
            if (loop_q) begin
              rom_addr_d = ADDR_W'(song_base(int'(song_q), ADDR_W, SONG_W));
              state_d    = FETCH;
            end else begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end else begin
            note_tone_d  = rom_tone(rom_data);
            dur_d        = rom_dur(rom_data);
            note_start_d = 1'b1;
            // Offset wraps inside the region; song bits never change.
            rom_addr_d   = {rom_addr_q[ADDR_W-1:OFF_W],
                            rom_addr_q[OFF_W-1:0] + OFF_W'(1)};
            state_d      = PLAY;
          end
        end
        PLAY: begin
          if (note_change) begin
            state_d = FETCH;
          end else if (pause) begin
            state_d = PAUSED;
          end
        end
        PAUSED: begin
          if (!pause) begin
            state_d = PLAY;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // The note tone is audible while a song is active and not paused.
    tone_out_d = ((state_d == FETCH) || (state_d == LOAD) || (state_d == PLAY))
                 ? note_tone_d : SILENCE;
    timer_en_d = (state_d == PLAY);
    busy_d     = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rom_addr_q   <= '0;
      song_q       <= '0;
      loop_q       <= 1'b0;
      note_tone_q  <= SILENCE;
      dur_q        <= 4'h0;
      tone_out_q   <= SILENCE;
      note_start_q <= 1'b0;
      timer_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rom_addr_q   <= rom_addr_d;
      song_q       <= song_d;
      loop_q       <= loop_d;
      note_tone_q  <= note_tone_d;
      dur_q        <= dur_d;
      tone_out_q   <= tone_out_d;
      note_start_q <= note_start_d;
      timer_en_q   <= timer_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign tone_out   = tone_out_q;
  assign dur_out    = dur_q;
  assign note_start = note_start_q;
  assign timer_en   = timer_en_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_song_ctrl.sv
// Directed testbench for song_ctrl with a registered song ROM model.
module tb_song_ctrl;

  logic       clk;
  logic       rst;
  logic       play;
  logic       stop;
  logic       pause;
  logic       loop;
  logic [1:0] song_sel;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic       note_change;
  logic       note_start;
  logic       timer_en;
  logic [3:0] dur_out;
  logic [3:0] tone_out;
  logic       busy;
  logic       done;

  logic [7:0] rom [256];
  int         checks;
  int         errors;
  int         done_cnt;
  int         ns_cnt;
  int         d0;
  int         n0;

  song_ctrl #(.ADDR_W(8), .SONG_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .play       (play),
    .stop       (stop),
    .pause      (pause),
    .loop       (loop),
    .song_sel   (song_sel),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .note_change(note_change),
    .note_start (note_start),
    .timer_en   (timer_en),
    .dur_out    (dur_out),
    .tone_out   (tone_out),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Song ROM with one cycle of read latency.
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Pulse counters for done and note_start.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      done_cnt <= 0;
      ns_cnt   <= 0;
    end else begin
      if (done) done_cnt <= done_cnt + 1;
      if (note_start) ns_cnt <= ns_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse play and wait until the first note is loaded.
  task automatic start(input logic [1:0] s, input logic lp);
    play = 1'b1; song_sel = s; loop = lp;
    tick(1);
    play = 1'b0;
    tick(2);
  endtask

  task automatic pulse_nc();
    note_change = 1'b1;
    tick(1);
    note_change = 1'b0;
  endtask

  initial begin
    rst = 1'b1; play = 1'b0; stop = 1'b0; pause = 1'b0; loop = 1'b0;
    song_sel = 2'd0; note_change = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[8'h40] = 8'h35;
    rom[8'h41] = 8'h27;
    rom[8'h42] = 8'h00;
    for (int j = 0; j < 64; j++) rom[8'hC0 + j] = {4'h1, 4'(j) ^ 4'h9};
    checks = 0;
    errors = 0;

    tick(2);
    check("rst_addr", rom_addr, 0);
    check("rst_tone", tone_out, 0);
    check("rst_dur", dur_out, 0);
    check("rst_ns", note_start, 0);
    check("rst_ten", timer_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    tick(1);

    // Song 1, no loop: two notes then end
    play = 1'b1; song_sel = 2'd1; loop = 1'b0;
    tick(1);
    play = 1'b0;
    check("s1_addr_base", rom_addr, 8'h40);
    check("s1_busy", busy, 1);
    check("s1_fetch_tone", tone_out, 0);
    check("s1_fetch_ten", timer_en, 0);
    tick(2);
    check("s1_n1_tone", tone_out, 5);
    check("s1_n1_dur", dur_out, 3);
    check("s1_n1_ns", note_start, 1);
    check("s1_n1_ten", timer_en, 1);
    check("s1_n1_addr", rom_addr, 8'h41);
    pulse_nc();
    check("s1_hold_f", tone_out, 5);
    check("s1_ns_low", note_start, 0);
    tick(1);
    check("s1_hold_l", tone_out, 5);
    tick(1);
    check("s1_n2_tone", tone_out, 7);
    check("s1_n2_dur", dur_out, 2);
    check("s1_n2_ns", note_start, 1);
    d0 = done_cnt;
    pulse_nc();
    tick(2);
    check("s1_done", done, 1);
    check("s1_busy_end", busy, 0);
    check("s1_tone_end", tone_out, 0);
    check("s1_ten_end", timer_en, 0);
    tick(1);
    check("s1_done_pulse", done, 0);
    check("s1_done_cnt", done_cnt, d0 + 1);

    // Song 1 with loop: wraps back to base after the end marker
    d0 = done_cnt;
    start(2'd1, 1'b1);
    check("lp_n1_tone", tone_out, 5);
    pulse_nc();
    tick(2);
    check("lp_n2_tone", tone_out, 7);
    pulse_nc();
    tick(2);
    check("lp_addr_base", rom_addr, 8'h40);
    check("lp_busy", busy, 1);
    tick(2);
    check("lp_again_tone", tone_out, 5);
    check("lp_again_dur", dur_out, 3);
    check("lp_again_ns", note_start, 1);
    check("lp_no_done", done_cnt, d0);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("lp_stop_busy", busy, 0);
    check("lp_stop_tone", tone_out, 0);
    check("lp_stop_done", done_cnt, d0);

    // Song 3 without an end marker: offset wraps inside the region
    start(2'd3, 1'b0);
    check("s3_first_addr", rom_addr, 8'hC1);
    for (int k = 1; k <= 64; k++) begin
      pulse_nc();
      tick(2);
      if (k == 62) check("s3_addr_fe_ff", rom_addr, 8'hFF);
      if (k == 63) begin
        check("s3_addr_wrap", rom_addr, 8'hC0);
        check("s3_tone_ff", tone_out, 4'hF ^ 4'h9);
      end
      if (k == 64) begin
        check("s3_addr_c1", rom_addr, 8'hC1);
        check("s3_tone_c0", tone_out, 4'h9);
      end
    end
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("s3_stop_busy", busy, 0);

    // Pause for 10 cycles, with a note_change that must be ignored
    start(2'd1, 1'b0);
    pause = 1'b1;
    tick(1);
    check("pz_tone", tone_out, 0);
    check("pz_ten", timer_en, 0);
    n0 = ns_cnt;
    tick(3);
    pulse_nc();
    tick(5);
    check("pz_tone_late", tone_out, 0);
    check("pz_busy", busy, 1);
    pause = 1'b0;
    tick(1);
    check("pz_rel_tone", tone_out, 5);
    check("pz_rel_ten", timer_en, 1);
    check("pz_rel_ns", note_start, 0);
    check("pz_ns_cnt", ns_cnt, n0);
    check("pz_rel_dur", dur_out, 3);

    // note_change and pause together: note_change first, pause next PLAY
    note_change = 1'b1; pause = 1'b1;
    tick(1);
    note_change = 1'b0;
    check("nc_pz_fetch_ten", timer_en, 0);
    check("nc_pz_fetch_tone", tone_out, 5);
    tick(2);
    check("nc_pz_tone", tone_out, 7);
    check("nc_pz_ns", note_start, 1);
    check("nc_pz_ten", timer_en, 1);
    tick(1);
    check("nc_pz_paused_tone", tone_out, 0);
    check("nc_pz_paused_ten", timer_en, 0);
    pause = 1'b0;

    // stop and play together while playing, then while idle
    d0 = done_cnt;
    stop = 1'b1; play = 1'b1;
    tick(1);
    stop = 1'b0; play = 1'b0;
    check("sp_busy", busy, 0);
    check("sp_tone", tone_out, 0);
    tick(1);
    check("sp_busy2", busy, 0);
    stop = 1'b1; play = 1'b1; song_sel = 2'd3;
    tick(1);
    stop = 1'b0; play = 1'b0;
    check("sp_idle_busy", busy, 0);
    check("sp_idle_addr", rom_addr, 8'h42);
    check("sp_no_done", done_cnt, d0);

    // Asynchronous reset during LOAD, then a clean restart
    start(2'd1, 1'b0);
    note_change = 1'b1;
    tick(1);
    note_change = 1'b0;
    tick(1);
    rst = 1'b1;
    #1;
    check("rl_addr", rom_addr, 0);
    check("rl_tone", tone_out, 0);
    check("rl_dur", dur_out, 0);
    check("rl_busy", busy, 0);
    check("rl_ten", timer_en, 0);
    tick(1);
    rst = 1'b0;
    tick(1);
    play = 1'b1; song_sel = 2'd1; loop = 1'b0;
    tick(1);
    play = 1'b0;
    check("rl_re_addr", rom_addr, 8'h40);
    tick(2);
    check("rl_re_tone", tone_out, 5);
    check("rl_re_ns", note_start, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
